output_link_tx: RTL and testbench

Transmit-side link stage of a router output port: the upstream end of the on/off flow-control link whose receiver is the downstream input-port circular buffer.
- Accepts one flit per cycle from switch traversal.
- Gates acceptance per VC on the downstream on/off signal.
- Registers the flit onto the link.
- Tracks packet framing per VC (HEAD/BODY/TAIL/HEADTAIL) and flags protocol errors.

---
 rtl/output_link_tx_pkg.sv | 17 +
 rtl/output_link_vc_tracker.sv | 73 +++++++
 rtl/output_link_tx.sv | 77 +++++++
 tb/tb_output_link_tx.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/output_link_tx_pkg.sv
// noc_params: shared NoC types, flit format and link-stage FSM states.
package noc_params;
    localparam int VC_NUM  = 2;
    localparam int VC_SIZE = 4;
    // One spare vc_id bit so out-of-range VC ids are representable and can be rejected.
    localparam int VC_ID_W = $clog2(VC_NUM) + 1;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
    typedef enum logic {TX_IDLE, TX_PKT} tx_state_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_ID_W-1:0]   vc_id;
        logic [DATA_W-1:0]    data;
    } flit_t;
endpackage

// File: rtl/output_link_vc_tracker.sv
// output_link_vc_tracker: per-VC packet framing check; optional counters under OUTPUT_LINK_TX_STATS_EN.
module output_link_vc_tracker
    import noc_params::*;
`ifdef OUTPUT_LINK_TX_STATS_EN
#(
    parameter int CNT_WIDTH = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept_i,
    input  flit_label_t flit_label_i,
    output logic        error_o
`ifdef OUTPUT_LINK_TX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] flit_cnt_o,
    output logic [CNT_WIDTH-1:0] pkt_cnt_o
`endif
);
    tx_state_t state_q, state_d;
    logic      err_q, err_d;
    logic      opener;

    assign opener  = (flit_label_i == HEAD) || (flit_label_i == HEADTAIL);
    assign error_o = err_q;

    // Framing FSM: idle expects an opener, in-packet expects a continuation; errors are sticky.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (accept_i) begin
            state_d = (state_q == TX_IDLE) ? ((flit_label_i == HEAD) ? TX_PKT : TX_IDLE)
                                           : ((flit_label_i == TAIL) ? TX_IDLE : TX_PKT);
            err_d   = err_q | ((state_q == TX_IDLE) ? !opener : opener);
        end
    end

    // Register FSM state and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TX_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

`ifdef OUTPUT_LINK_TX_STATS_EN
    logic [CNT_WIDTH-1:0] flit_cnt_q, flit_cnt_d, pkt_cnt_q, pkt_cnt_d;

    assign flit_cnt_o = flit_cnt_q;
    assign pkt_cnt_o  = pkt_cnt_q;

    // Wrapping counters: every accepted flit, and every accepted packet-closing flit.
    always_comb begin
        flit_cnt_d = flit_cnt_q + CNT_WIDTH'(accept_i);
        pkt_cnt_d  = pkt_cnt_q + CNT_WIDTH'(accept_i && ((flit_label_i == TAIL) || (flit_label_i == HEADTAIL)));
    end

    // Register the counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end
`endif
endmodule

// File: rtl/output_link_tx.sv
// output_link_tx: on/off flow-controlled transmit link stage; OUTPUT_LINK_TX_STATS_EN adds per-VC counters.
module output_link_tx
    import noc_params::*;
#(
    parameter int VC_NUM         = noc_params::VC_NUM,
    parameter int PIPELINE_DEPTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  flit_t             data_i,
    input  logic [VC_NUM-1:0] on_off_i,
    output logic [VC_NUM-1:0] ready_o,
    output logic              valid_o,
    output flit_t             data_o,
    output logic [VC_NUM-1:0] error_o
`ifdef OUTPUT_LINK_TX_STATS_EN
    ,
    output logic [VC_NUM-1:0][CNT_WIDTH-1:0] flit_cnt_o,
    output logic [VC_NUM-1:0][CNT_WIDTH-1:0] pkt_cnt_o
`endif
);
    // Downstream slack must absorb the on/off sync stage plus the output stage.
    if (PIPELINE_DEPTH < 2 || CNT_WIDTH < 1) begin : g_cfg_check
        $error("output_link_tx: PIPELINE_DEPTH must be >= 2 and CNT_WIDTH >= 1");
    end

    logic [VC_NUM-1:0] on_q, on_d, acc_vec;
    logic              valid_q, valid_d;
    flit_t             data_q, data_d;

    assign ready_o = on_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Per-VC accept decode; ids outside the VC range match no bit and are dropped.
    always_comb begin
        on_d = on_off_i;
        for (int v = 0; v < VC_NUM; v++)
            acc_vec[v] = valid_i && (data_i.vc_id == VC_ID_W'(v)) && on_q[v];
        valid_d = |acc_vec;
        data_d  = valid_d ? data_i : data_q;
    end

    // On/off sync stage and link output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            on_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            on_q    <= on_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
        output_link_vc_tracker
`ifdef OUTPUT_LINK_TX_STATS_EN
            #(.CNT_WIDTH(CNT_WIDTH))
`endif
        u_trk (
            .clk          (clk),
            .rst          (rst),
            .accept_i     (acc_vec[g]),
            .flit_label_i (data_i.flit_label),
            .error_o      (error_o[g])
`ifdef OUTPUT_LINK_TX_STATS_EN
            ,
            .flit_cnt_o   (flit_cnt_o[g]),
            .pkt_cnt_o    (pkt_cnt_o[g])
`endif
        );
    end
endmodule

// File: tb/tb_output_link_tx.sv
// tb_output_link_tx: scoreboard bench for output_link_tx (stats checks when OUTPUT_LINK_TX_STATS_EN is defined).
module tb_output_link_tx;
    import noc_params::*;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    flit_t       data_i = '0;
    logic [1:0]  on_off_i = 2'b00;
    logic [1:0]  ready_o;
    logic        valid_o;
    flit_t       data_o;
    logic [1:0]  error_o;
`ifdef OUTPUT_LINK_TX_STATS_EN
    logic [1:0][CW-1:0] flit_cnt_o, pkt_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    flit_t sb[$];

    output_link_tx #(.VC_NUM(2), .PIPELINE_DEPTH(5), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .on_off_i (on_off_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .error_o  (error_o)
`ifdef OUTPUT_LINK_TX_STATS_EN
        ,
        .flit_cnt_o (flit_cnt_o),
        .pkt_cnt_o  (pkt_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one flit for one cycle starting at a negedge; push it if it must be accepted.
    task automatic send(input flit_label_t lbl, input int vc, input logic [15:0] d, input bit exp_acc);
        valid_i = 1'b1;
        data_i.flit_label = lbl;
        data_i.vc_id = VC_ID_W'(vc);
        data_i.data = d;
        if (exp_acc) sb.push_back(data_i);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    // Monitor: every link flit must match the oldest expected flit.
    always @(posedge clk) begin
        #2;
        if (valid_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flit: got %0h expected none", data_o);
            end else begin
                flit_t e;
                e = sb.pop_front();
                if (data_o !== e) begin
                    errors++;
                    $display("FAIL link_flit: got %0h expected %0h", data_o, e);
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(valid_o), 0);
        check("reset_ready", 32'(ready_o), 0);
        check("reset_error", 32'(error_o), 0);
        rst = 1'b1;
        on_off_i = 2'b11;
        @(negedge clk);
        check("ready_after_reset", 32'(ready_o), 32'h3);

        send(HEAD, 0, 16'hA001, 1);
        send(BODY, 0, 16'hA002, 1);
        send(TAIL, 0, 16'hA003, 1);
        @(negedge clk);
        check("idle_after_packet", 32'(valid_o), 0);
        check("no_error_packet", 32'(error_o), 0);

        on_off_i = 2'b01;
        @(negedge clk);
        check("ready_vc1_off", 32'(ready_o), 32'h1);
        send(HEAD, 1, 16'hB000, 0);
        check("vc1_dropped", 32'(valid_o), 0);
        send(HEADTAIL, 0, 16'hA010, 1);
        check("vc0_passes", 32'(valid_o), 1);
        send(HEAD, 2, 16'hC000, 0);
        check("bad_vc_dropped", 32'(valid_o), 0);
        check("drops_no_error", 32'(error_o), 0);

        on_off_i = 2'b11;
        @(negedge clk);
        send(BODY, 1, 16'hB001, 1);
        check("body_idle_err", 32'(error_o), 32'h2);
        repeat (10) @(negedge clk);
        check("err_sticky", 32'(error_o), 32'h2);

        send(HEADTAIL, 0, 16'hA020, 1);
        send(HEAD, 0, 16'hA021, 1);
        send(TAIL, 0, 16'hA022, 1);
        check("vc0_clean", 32'(error_o[0]), 0);
        send(HEAD, 0, 16'hA030, 1);
        send(HEAD, 0, 16'hA031, 1);
        check("head_head_err", 32'(error_o), 32'h3);

        send(HEAD, 1, 16'hB010, 1);
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(valid_o), 0);
        check("async_rst_ready", 32'(ready_o), 0);
        check("async_rst_error", 32'(error_o), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst2", 32'(ready_o), 32'h3);
        send(HEADTAIL, 0, 16'hA040, 1);
        send(TAIL, 1, 16'hB020, 1);
        check("fsm_reset_idle", 32'(error_o), 32'h2);

`ifdef OUTPUT_LINK_TX_STATS_EN
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) send(HEADTAIL, 0, 16'(i), 1);
        check("flit_cnt_wrap", 32'(flit_cnt_o[0]), 1);
        check("pkt_cnt_wrap", 32'(pkt_cnt_o[0]), 1);
        check("flit_cnt_vc1", 32'(flit_cnt_o[1]), 0);
        on_off_i = 2'b10;
        @(negedge clk);
        send(HEADTAIL, 0, 16'hDEAD, 0);
        check("dropped_no_count", 32'(flit_cnt_o[0]), 1);
        check("dropped_no_pkt", 32'(pkt_cnt_o[0]), 1);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
